cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_addr_split.sv | 21 ++
 rtl/cache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split constants
// for the direct-mapped cache controller.
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int WADDR_W     = 30;
  localparam int OFF_W       = 2;
  localparam int LINE_ADDR_W = 28;
  localparam int BEATS       = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WBACK,
    S_REFILL
  } state_e;

  typedef logic [OFF_W-1:0] cnt_t;

  // Word-aligned beat address from a line
  // address ({tag,index}) and a word offset.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [LINE_ADDR_W-1:0] line,
    input cnt_t                   beat
  );
    return {line, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_addr_split.sv
// Splits a word address into tag,
// line index and word offset.
module cache_addr_split
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2
) (
  input  logic [WADDR_W-1:0]               waddr,
  output logic [LINE_ADDR_W-INDEX_W-1:0]   tag,
  output logic [INDEX_W-1:0]               index,
  output logic [OFF_W-1:0]                 offset
);

  // Pure field extraction.
  always_comb begin
    tag    = waddr[WADDR_W-1:INDEX_W+OFF_W];
    index  = waddr[INDEX_W+OFF_W-1:OFF_W];
    offset = waddr[OFF_W-1:0];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller:
// compare, 4-beat write-back, 4-beat refill.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2
) (
  input  logic                       CLK,
  input  logic                       ResetN,
  input  logic                       Req,
  input  logic                       ReqWE,
  input  logic [ADDR_W-1:0]          Addr,
  input  logic [WORD_W-1:0]          WData,
  output logic                       Ready,
  output logic [WORD_W-1:0]          RData,
  output logic [INDEX_W-1:0]         BlkIndex,
  output logic [OFF_W-1:0]           BlkOffset,
  output logic                       BlkWE,
  output logic                       BlkSetValid,
  output logic                       BlkSetDirty,
  output logic [27-INDEX_W:0]        BlkSetTag,
  output logic [WORD_W-1:0]          BlkWD,
  input  logic                       BlkValid,
  input  logic                       BlkDirty,
  input  logic [27-INDEX_W:0]        BlkTag,
  input  logic [WORD_W-1:0]          BlkRD,
  output logic                       MemReq,
  output logic                       MemWE,
  output logic [ADDR_W-1:0]          MemAddr,
  output logic [WORD_W-1:0]          MemWD,
  input  logic [WORD_W-1:0]          MemRD,
  input  logic                       MemAck
);

  localparam int TAG_W = LINE_ADDR_W - INDEX_W;

  state_e               state, state_d;
  cnt_t                 cnt, cnt_d;
  logic [WADDR_W-1:0]   waddr_q;
  logic                 we_q;
  logic [WORD_W-1:0]    wdata_q;
  logic                 load_en;
  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [OFF_W-1:0]     off_q;
  logic                 hit;
  logic                 last;
  logic                 unused_ok;

  // Byte lane bits carry no meaning here.
  assign unused_ok = ^Addr[1:0];

  cache_addr_split #(
    .INDEX_W (INDEX_W)
  ) u_split (
    .waddr  (waddr_q),
    .tag    (tag_q),
    .index  (idx_q),
    .offset (off_q)
  );

  assign hit      = BlkValid && (BlkTag == tag_q);
  assign last     = (cnt == cnt_t'(BEATS - 1));
  assign BlkIndex = idx_q;

  // State and beat counter.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Request capture, only accepted in IDLE.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      waddr_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (load_en) begin
      waddr_q <= Addr[ADDR_W-1:2];
      we_q    <= ReqWE;
      wdata_q <= WData;
    end
  end

  // Next state and all strobes.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    load_en     = 1'b0;
    Ready       = 1'b0;
    RData       = '0;
    BlkOffset   = off_q;
    BlkWE       = 1'b0;
    BlkSetValid = 1'b0;
    BlkSetDirty = 1'b0;
    BlkSetTag   = '0;
    BlkWD       = '0;
    MemReq      = 1'b0;
    MemWE       = 1'b0;
    MemAddr     = '0;
    MemWD       = '0;
    unique case (state)
      S_IDLE: begin
        if (Req) begin
          load_en = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          Ready   = 1'b1;
          state_d = S_IDLE;
          if (we_q) begin
            BlkWE       = 1'b1;
            BlkWD       = wdata_q;
            BlkSetValid = 1'b1;
            BlkSetDirty = 1'b1;
            BlkSetTag   = tag_q;
          end else begin
            RData = BlkRD;
          end
        end else begin
          cnt_d = '0;
          if (BlkValid && BlkDirty)
            state_d = S_WBACK;
          else
            state_d = S_REFILL;
        end
      end
      S_WBACK: begin
        MemReq    = 1'b1;
        MemWE     = 1'b1;
        BlkOffset = cnt;
        MemAddr   = beat_addr({BlkTag, idx_q}, cnt);
        MemWD     = BlkRD;
        if (MemAck) begin
          cnt_d = cnt + 2'd1;
          if (last)
            state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        MemReq    = 1'b1;
        BlkOffset = cnt;
        MemAddr   = beat_addr({tag_q, idx_q}, cnt);
        if (MemAck) begin
          BlkWE       = 1'b1;
          BlkWD       = MemRD;
          BlkSetTag   = tag_q;
          BlkSetValid = last;
          cnt_d       = cnt + 2'd1;
          if (last)
            state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl with a
// line-array model, memory responder, scoreboard.
module tb_cache_ctrl;

  localparam int IW = 2;
  localparam int TW = 28 - IW;

  logic          CLK;
  logic          ResetN;
  logic          Req;
  logic          ReqWE;
  logic [31:0]   Addr;
  logic [31:0]   WData;
  logic          Ready;
  logic [31:0]   RData;
  logic [IW-1:0] BlkIndex;
  logic [1:0]    BlkOffset;
  logic          BlkWE;
  logic          BlkSetValid;
  logic          BlkSetDirty;
  logic [TW-1:0] BlkSetTag;
  logic [31:0]   BlkWD;
  logic          BlkValid;
  logic          BlkDirty;
  logic [TW-1:0] BlkTag;
  logic [31:0]   BlkRD;
  logic          MemReq;
  logic          MemWE;
  logic [31:0]   MemAddr;
  logic [31:0]   MemWD;
  logic [31:0]   MemRD;
  logic          MemAck;

  cache_ctrl #(.INDEX_W(IW)) dut (
    .CLK         (CLK),
    .ResetN      (ResetN),
    .Req         (Req),
    .ReqWE       (ReqWE),
    .Addr        (Addr),
    .WData       (WData),
    .Ready       (Ready),
    .RData       (RData),
    .BlkIndex    (BlkIndex),
    .BlkOffset   (BlkOffset),
    .BlkWE       (BlkWE),
    .BlkSetValid (BlkSetValid),
    .BlkSetDirty (BlkSetDirty),
    .BlkSetTag   (BlkSetTag),
    .BlkWD       (BlkWD),
    .BlkValid    (BlkValid),
    .BlkDirty    (BlkDirty),
    .BlkTag      (BlkTag),
    .BlkRD       (BlkRD),
    .MemReq      (MemReq),
    .MemWE       (MemWE),
    .MemAddr     (MemAddr),
    .MemWD       (MemWD),
    .MemRD       (MemRD),
    .MemAck      (MemAck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } rdy_t;

  beat_t sb_beat[$];
  rdy_t  sb_rdy[$];

  int vectors;
  int miscompares;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Line array owned by the bench.
  logic          arr_clr;
  logic          arr_v [4];
  logic          arr_d [4];
  logic [TW-1:0] arr_t [4];
  logic [31:0]   arr_w [4][4];

  assign BlkValid = arr_v[BlkIndex];
  assign BlkDirty = arr_d[BlkIndex];
  assign BlkTag   = arr_t[BlkIndex];
  assign BlkRD    = arr_w[BlkIndex][BlkOffset];

  always @(posedge CLK) begin
    if (arr_clr) begin
      for (int i = 0; i < 4; i++) begin
        arr_v[i] <= 1'b0;
        arr_d[i] <= 1'b0;
        arr_t[i] <= '0;
        for (int j = 0; j < 4; j++)
          arr_w[i][j] <= '0;
      end
    end else if (BlkWE) begin
      arr_v[BlkIndex] <= BlkSetValid;
      arr_d[BlkIndex] <= BlkSetDirty;
      arr_t[BlkIndex] <= BlkSetTag;
      arr_w[BlkIndex][BlkOffset] <= BlkWD;
    end
  end

  // Backing memory.
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(
    input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Reference cache contents.
  bit          rv [4];
  bit          rdt [4];
  logic [TW-1:0] rt [4];
  logic [31:0] rl [4][4];

  task automatic ref_clear();
    for (int i = 0; i < 4; i++) begin
      rv[i]  = 0;
      rdt[i] = 0;
      rt[i]  = '0;
      for (int j = 0; j < 4; j++)
        rl[i][j] = '0;
    end
  endtask

  task automatic expect_access(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic        hit);
    logic [1:0]    ix;
    logic [1:0]    of;
    logic [TW-1:0] tg;
    logic [1:0]    c2;
    beat_t         b;
    rdy_t          r;
    ix  = a[5:4];
    of  = a[3:2];
    tg  = a[31:6];
    hit = rv[ix] && (rt[ix] == tg);
    if (!hit) begin
      if (rv[ix] && rdt[ix])
        for (int c = 0; c < 4; c++) begin
          c2     = 2'(c);
          b.we   = 1'b1;
          b.addr = {rt[ix], ix, c2, 2'b00};
          b.data = rl[ix][c];
          sb_beat.push_back(b);
        end
      for (int c = 0; c < 4; c++) begin
        c2     = 2'(c);
        b.we   = 1'b0;
        b.addr = {tg, ix, c2, 2'b00};
        b.data = mem_rd(b.addr);
        sb_beat.push_back(b);
        rl[ix][c] = b.data;
      end
      rv[ix]  = 1;
      rt[ix]  = tg;
      rdt[ix] = 0;
    end
    if (we) begin
      rl[ix][of] = d;
      rdt[ix]    = 1;
    end
    r.we   = we;
    r.data = rl[ix][of];
    sb_rdy.push_back(r);
  endtask

  // Memory responder with programmable latency.
  int          ackdly;
  bit          stray;
  bit          busy;
  bit          stable;
  int          wcnt;
  logic [31:0] baddr;
  logic [31:0] bwd;
  logic        bwe;
  beat_t       eb;

  initial begin
    MemAck = 1'b0;
    MemRD  = '0;
    busy   = 0;
    forever begin
      @(negedge CLK);
      MemAck = 1'b0;
      if (!ResetN || !MemReq) begin
        busy   = 0;
        MemAck = stray;
        continue;
      end
      if (!busy) begin
        busy   = 1;
        wcnt   = 0;
        baddr  = MemAddr;
        bwd    = MemWD;
        bwe    = MemWE;
        stable = 1;
      end else if (MemAddr !== baddr ||
                   MemWD !== bwd ||
                   MemWE !== bwe) begin
        stable = 0;
      end
      if (wcnt < ackdly) begin
        wcnt++;
      end else begin
        busy = 0;
        check("beat_expected",
              32'(sb_beat.size() > 0), 1);
        if (sb_beat.size() > 0)
          eb = sb_beat.pop_front();
        else
          eb = '0;
        check("beat_stable", 32'(stable), 1);
        check("beat_we", bwe, eb.we);
        check("beat_addr", baddr, eb.addr);
        check("beat_off", BlkOffset, baddr[3:2]);
        if (bwe) begin
          check("wb_data", bwd, eb.data);
          mem[baddr] = bwd;
          MemAck = 1'b1;
        end else begin
          MemRD  = mem_rd(baddr);
          MemAck = 1'b1;
          #1;
          check("rf_flags",
                {BlkWE, BlkSetValid, BlkSetDirty},
                {1'b1, baddr[3:2] == 2'd3, 1'b0});
          check("rf_wd", BlkWD, eb.data);
        end
      end
    end
  end

  task automatic access(input logic        we,
                        input logic [31:0] a,
                        input logic [31:0] d);
    logic hit;
    int   cyc;
    bit   done;
    rdy_t e;
    expect_access(we, a, d, hit);
    Req   = 1'b1;
    ReqWE = we;
    Addr  = a;
    WData = d;
    cyc   = 0;
    done  = 0;
    while (!done && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        Addr  = $urandom;
        WData = $urandom;
        ReqWE = ~we;
      end
      if (Ready) begin
        done = 1;
        check("rdy_expected",
              32'(sb_rdy.size() > 0), 1);
        if (sb_rdy.size() > 0)
          e = sb_rdy.pop_front();
        else
          e = '0;
        if (e.we) begin
          check("st_strobe",
                {BlkWE, BlkSetValid, BlkSetDirty},
                3'b111);
          check("st_wd", BlkWD, e.data);
          check("st_memreq", MemReq, 0);
        end else begin
          check("rdata", RData, e.data);
        end
      end
    end
    check("ready_seen", 32'(done), 1);
    if (hit) check("hit_latency", cyc + 1, 2);
    check("beats_left", sb_beat.size(), 0);
    @(negedge CLK);
    Req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic        h;
    logic [31:0] a;
    bit          found;
    bit          bad;
    vectors     = 0;
    miscompares = 0;
    ackdly      = 0;
    stray       = 0;
    ResetN      = 1'b0;
    Req         = 1'b0;
    ReqWE       = 1'b0;
    Addr        = '0;
    WData       = '0;
    arr_clr     = 1'b1;
    ref_clear();

    repeat (3) @(negedge CLK);
    check("rst_ready", Ready, 0);
    check("rst_mem", {MemReq, MemWE}, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_blk",
          {BlkWE, BlkIndex, BlkOffset}, 0);
    arr_clr = 1'b0;
    ResetN  = 1'b1;
    @(negedge CLK);

    access(0, 32'h0000_0010, 0);
    stray = 1;
    access(0, 32'h0000_0018, 0);
    stray = 0;
    repeat (2) @(negedge CLK);
    access(1, 32'h0000_0014, 32'hDEAD_BEEF);
    access(0, 32'h0000_0014, 0);
    access(1, 32'h0000_0064, 32'h1234_5678);
    access(0, 32'h0000_00A0, 0);

    ackdly = 5;
    access(0, 32'h0000_0064, 0);
    access(1, 32'h0000_00E8, 32'hCAFE_F00D);
    access(0, 32'h0000_0128, 0);

    ackdly = 1;
    for (int i = 0; i < 8; i++) begin
      a = (32'($urandom_range(0, 3)) << 6) |
          (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom_range(0, 1)), a,
             $urandom);
    end

    ackdly = 3;
    expect_access(0, 32'h0000_0200, 0, h);
    Req   = 1'b1;
    ReqWE = 1'b0;
    Addr  = 32'h0000_0200;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge CLK);
      if (MemReq && !MemWE && MemAddr[3:2] == 2'd2)
        found = 1;
    end
    check("rst_reach", 32'(found), 1);
    #2;
    ResetN = 1'b0;
    #1;
    check("rst_memreq", MemReq, 0);
    check("rst_noready", Ready, 0);
    Req     = 1'b0;
    arr_clr = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst2_memaddr", MemAddr, 0);
    check("rst2_rdata", RData, 0);
    check("rst2_blk",
          {BlkWE, BlkIndex, BlkOffset, MemReq}, 0);
    sb_beat.delete();
    sb_rdy.delete();
    ref_clear();
    arr_clr = 1'b0;
    ResetN  = 1'b1;
    bad     = 0;
    repeat (10) begin
      @(negedge CLK);
      if (Ready || MemReq || BlkWE) bad = 1;
    end
    check("post_rst_quiet", 32'(bad), 0);

    ackdly = 0;
    access(0, 32'h0000_0010, 0);
    check("sb_beat_empty", sb_beat.size(), 0);
    check("sb_rdy_empty", sb_rdy.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
